// File: rtl/alu_pkg.sv
// Shared opcode and width definitions for the MIPS execute-stage ALU.
// Imported by the ALU top level, its shifter and any ALU-control decode logic.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int OP_W    = 4;

   localparam logic [OP_W-1:0] ALU_NOP  = 4'd0;
   localparam logic [OP_W-1:0] ALU_ADD  = 4'd1;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'd2;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'd3;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'd4;
   localparam logic [OP_W-1:0] ALU_AND  = 4'd5;
   localparam logic [OP_W-1:0] ALU_OR   = 4'd6;
   localparam logic [OP_W-1:0] ALU_NOR  = 4'd7;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'd8;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'd9;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'd10;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by SLL, SRL and (with ALU_SRA_EN) SRA.
// Without ALU_SRA_EN the arithmetic select port and its sign-fill path do not exist.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic               right_i,
`ifdef ALU_SRA_EN
   input  logic               arith_i,
`endif
   output logic [DATA_W-1:0]  data_o
);

   logic [DATA_W-1:0] right_d;

`ifdef ALU_SRA_EN
   logic [2*DATA_W-1:0] ext_d;

   // Prepend a fill word so one logical shift covers both SRL and SRA.
   always_comb begin
      ext_d   = {{DATA_W{arith_i & data_i[DATA_W-1]}}, data_i} >> shamt_i;
      right_d = ext_d[DATA_W-1:0];
   end
`else
   always_comb begin
      right_d = data_i >> shamt_i;
   end
`endif

   always_comb begin
      data_o = right_i ? right_d : (data_i << shamt_i);
   end

endmodule

// File: rtl/alu.sv
// Registered 32-bit MIPS ALU: op mux, comparators and output registers, one-cycle latency.
// Build option: define ALU_SRA_EN to enable opcode 10 as arithmetic right shift.
module alu
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  InputData1,
   input  logic [DATA_W-1:0]  InputData2,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [OP_W-1:0]    ALU_Control,
   output logic [DATA_W-1:0]  ALU_Result,
   output logic               Zero
);

   logic [DATA_W-1:0] shift_d;
   logic [DATA_W-1:0] result_d, result_q;
   logic              zero_d, zero_q;
   logic              shift_right_d;

`ifdef ALU_SRA_EN
   assign shift_right_d = (ALU_Control == ALU_SRL) || (ALU_Control == ALU_SRA);
`else
   assign shift_right_d = (ALU_Control == ALU_SRL);
`endif

   alu_shifter u_shifter (
      .data_i  (InputData2),
      .shamt_i (shamt),
      .right_i (shift_right_d),
`ifdef ALU_SRA_EN
      .arith_i (ALU_Control == ALU_SRA),
`endif
      .data_o  (shift_d)
   );

   // NOTE: default first so every opcode path assigns result_d and no latch is inferred.
   always_comb begin
      result_d = '0;
      unique case (ALU_Control)
         ALU_ADD:  result_d = InputData1 + InputData2;
         ALU_SUB:  result_d = InputData1 - InputData2;
         ALU_SLL:  result_d = shift_d;
         ALU_SRL:  result_d = shift_d;
         ALU_AND:  result_d = InputData1 & InputData2;
         ALU_OR:   result_d = InputData1 | InputData2;
         ALU_NOR:  result_d = ~(InputData1 | InputData2);
         ALU_SLTU: result_d = {{(DATA_W-1){1'b0}}, (InputData1 < InputData2)};
         ALU_SLT:  result_d = {{(DATA_W-1){1'b0}}, ($signed(InputData1) < $signed(InputData2))};
`ifdef ALU_SRA_EN
         ALU_SRA:  result_d = shift_d;
`endif
         default:  result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   // NOTE: non-blocking assignments for registered state; reset wins over any op.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign ALU_Result = result_q;
   assign Zero       = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU; expected values are hand-computed.
// Define ALU_SRA_EN for both bench and RTL to exercise the arithmetic shift.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b;
   logic [4:0]  sh;
   logic [3:0]  op;
   logic [31:0] res;
   logic        zero;

   int checks = 0;
   int errors = 0;

   alu dut (
      .clk         (clk),
      .rst         (rst),
      .InputData1  (a),
      .InputData2  (b),
      .shamt       (sh),
      .ALU_Control (op),
      .ALU_Result  (res),
      .Zero        (zero)
   );

   always #5 clk = ~clk;

   // Present one operation, then let one rising edge sample it.
   task automatic apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s);
      op = o;
      a  = x;
      b  = y;
      sh = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(4'd1, 32'h1, 32'h2, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reset: got %h z=%b want 00000000 z=1", res, zero);
      end
      rst = 1'b0;
   endtask

   task automatic test_arith();
      apply(4'd1, 32'hFFFFFFFF, 32'h1, 5'd7);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap: got %h z=%b want 00000000 z=1", res, zero);
      end
      apply(4'd2, 32'hFFFFFFFF, 32'h1, 5'd0);
      checks++;
      if (res !== 32'hFFFFFFFE || zero !== 1'b0) begin
         errors++;
         $display("FAIL sub: got %h z=%b want fffffffe z=0", res, zero);
      end
      apply(4'd1, 32'h00001234, 32'h00010000, 5'd31);
      checks++;
      if (res !== 32'h00011234 || zero !== 1'b0) begin
         errors++;
         $display("FAIL add_shamt_ignored: got %h z=%b want 00011234 z=0", res, zero);
      end
   endtask

   task automatic test_shift();
      apply(4'd3, 32'hDEADBEEF, 32'h5, 5'd3);
      checks++;
      if (res !== 32'h00000028 || zero !== 1'b0) begin
         errors++;
         $display("FAIL sll: got %h z=%b want 00000028 z=0", res, zero);
      end
      apply(4'd4, 32'hDEADBEEF, 32'h5, 5'd2);
      checks++;
      if (res !== 32'h00000001) begin
         errors++;
         $display("FAIL srl: got %h want 00000001", res);
      end
      apply(4'd3, 32'hFFFFFFFF, 32'h12345678, 5'd0);
      checks++;
      if (res !== 32'h12345678) begin
         errors++;
         $display("FAIL sll_shamt0: got %h want 12345678", res);
      end
      apply(4'd4, 32'h0, 32'h80000000, 5'd31);
      checks++;
      if (res !== 32'h00000001) begin
         errors++;
         $display("FAIL srl_31: got %h want 00000001", res);
      end
      apply(4'd4, 32'h0, 32'h80000000, 5'd4);
      checks++;
      if (res !== 32'h08000000) begin
         errors++;
         $display("FAIL srl_zero_fill: got %h want 08000000", res);
      end
`ifdef ALU_SRA_EN
      apply(4'd10, 32'h0, 32'h80000000, 5'd4);
      checks++;
      if (res !== 32'hF8000000 || zero !== 1'b0) begin
         errors++;
         $display("FAIL sra: got %h z=%b want f8000000 z=0", res, zero);
      end
      apply(4'd10, 32'h0, 32'h40000000, 5'd4);
      checks++;
      if (res !== 32'h04000000) begin
         errors++;
         $display("FAIL sra_pos: got %h want 04000000", res);
      end
`else
      apply(4'd10, 32'h0, 32'h80000000, 5'd4);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL op10_reserved: got %h z=%b want 00000000 z=1", res, zero);
      end
`endif
   endtask

   task automatic test_logic();
      apply(4'd5, 32'hFFFFFFFF, 32'h1, 5'd9);
      checks++;
      if (res !== 32'h00000001 || zero !== 1'b0) begin
         errors++;
         $display("FAIL and: got %h z=%b want 00000001 z=0", res, zero);
      end
      apply(4'd6, 32'hFFFFFFFF, 32'h1, 5'd0);
      checks++;
      if (res !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL or: got %h want ffffffff", res);
      end
      apply(4'd7, 32'hFFFFFFFF, 32'h1, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL nor: got %h z=%b want 00000000 z=1", res, zero);
      end
      apply(4'd7, 32'hF0F0F0F0, 32'h0000FFFF, 5'd0);
      checks++;
      if (res !== 32'h0F0F0000) begin
         errors++;
         $display("FAIL nor_mixed: got %h want 0f0f0000", res);
      end
   endtask

   task automatic test_compare();
      apply(4'd8, 32'hFFFFFFFF, 32'h1, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL sltu: got %h z=%b want 00000000 z=1", res, zero);
      end
      apply(4'd9, 32'hFFFFFFFE, 32'h1, 5'd0);
      checks++;
      if (res !== 32'h1 || zero !== 1'b0) begin
         errors++;
         $display("FAIL slt: got %h z=%b want 00000001 z=0", res, zero);
      end
      apply(4'd8, 32'h1, 32'hFFFFFFFE, 5'd0);
      checks++;
      if (res !== 32'h1) begin
         errors++;
         $display("FAIL sltu_true: got %h want 00000001", res);
      end
      apply(4'd9, 32'h1, 32'hFFFFFFFE, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL slt_false: got %h z=%b want 00000000 z=1", res, zero);
      end
   endtask

   task automatic test_reserved();
      apply(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reserved12: got %h z=%b want 00000000 z=1", res, zero);
      end
      apply(4'd15, 32'h12345678, 32'h1, 5'd1);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reserved15: got %h z=%b want 00000000 z=1", res, zero);
      end
   endtask

   task automatic test_back_to_back();
      // Each check runs right after the edge that sampled its op; next op then goes in.
      apply(4'd1, 32'd10, 32'd20, 5'd0);
      checks++;
      if (res !== 32'd30) begin
         errors++;
         $display("FAIL b2b_add: got %h want 0000001e", res);
      end
      apply(4'd2, 32'd10, 32'd10, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL b2b_sub: got %h z=%b want 00000000 z=1", res, zero);
      end
      apply(4'd3, 32'h0, 32'h1, 5'd31);
      checks++;
      if (res !== 32'h80000000 || zero !== 1'b0) begin
         errors++;
         $display("FAIL b2b_sll: got %h z=%b want 80000000 z=0", res, zero);
      end
      @(posedge clk);
      #1;
      checks++;
      if (res !== 32'h80000000) begin
         errors++;
         $display("FAIL b2b_hold: got %h want 80000000", res);
      end
   endtask

   task automatic test_mid_reset();
      apply(4'd6, 32'hA5A50000, 32'h00005A5A, 5'd0);
      rst = 1'b1;
      apply(4'd1, 32'd7, 32'd8, 5'd0);
      checks++;
      if (res !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got %h z=%b want 00000000 z=1", res, zero);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (res !== 32'd15 || zero !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got %h z=%b want 0000000f z=0", res, zero);
      end
   endtask

   initial begin
      rst = 1'b1;
      op  = 4'd0;
      a   = 32'h0;
      b   = 32'h0;
      sh  = 5'd0;
      test_reset();
      test_arith();
      test_shift();
      test_logic();
      test_compare();
      test_reserved();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
